// File: rtl/yarvi_uart_pkg.sv
// Shared types and constants for the yarvi_uart block: FSM state encoding,
// data width, RX FIFO depth and the 8N1 frame length.
package yarvi_uart_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/yarvi_uart_if.sv
// SoC-side byte handshakes plus the serial pins of yarvi_uart.
// The master is the SoC or bench; the slave is the UART.
interface yarvi_uart_if;
    import yarvi_uart_pkg::*;

    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              uart_txd;
    logic              uart_rxd;
    logic              rx_overrun;
    logic              rx_frame_err;

    modport master (
        output tx_valid, tx_data, rx_ready, uart_rxd,
        input  tx_ready, rx_valid, rx_data, uart_txd, rx_overrun, rx_frame_err
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready, uart_rxd,
        output tx_ready, rx_valid, rx_data, uart_txd, rx_overrun, rx_frame_err
    );

endinterface

// File: rtl/yarvi_uart_fifo.sv
// Small byte FIFO for received data; valid/ready on both sides.
// A pop in the same cycle lets a push into a full FIFO succeed.
module yarvi_uart_fifo
    import yarvi_uart_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready_c,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_rd;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_valid   = (r_count != '0);
    assign o_data    = r_mem[r_rd];
    assign w_pop     = o_valid && i_ready;
    assign o_ready_c = (r_count != CNT_W'(FIFO_DEPTH)) || i_ready;
    assign w_push    = i_valid && o_ready_c;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/yarvi_uart.sv
// Full-duplex 8N1 UART with valid/ready byte interfaces.
// Define UART_RX_FIFO_EN for a 4-entry RX FIFO; otherwise RX uses one holding register.
module yarvi_uart
    import yarvi_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic        clock,
    input  logic        reset_n,
    yarvi_uart_if.slave bus
);

    // DIV must be at least 4 so the half-bit delay is non-zero
    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

    uart_state_e       r_tx_state;
    logic              r_tx_ready;
    logic              r_txd;
    logic [CW-1:0]     r_tx_cnt;
    logic [2:0]        r_tx_bit;
    logic [DATA_W-1:0] r_tx_shift;

    uart_state_e       r_rx_state;
    logic              r_rxd_meta;
    logic              r_rxd_sync;
    logic [CW-1:0]     r_rx_cnt;
    logic [2:0]        r_rx_bit;
    logic [DATA_W-1:0] r_rx_shift;
    logic              r_rx_brk;
    logic              r_overrun;
    logic              r_frame_err;

    logic              w_rx_done;
    logic              w_rx_ferr;

    assign bus.tx_ready     = r_tx_ready;
    assign bus.uart_txd     = r_txd;
    assign bus.rx_overrun   = r_overrun;
    assign bus.rx_frame_err = r_frame_err;

    // Transmitter: the shift register drains LSB first into r_txd
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_tx_state <= ST_IDLE;
            r_tx_ready <= 1'b0;
            r_txd      <= 1'b1;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
        end else begin
            case (r_tx_state)
                ST_IDLE: begin
                    r_txd <= 1'b1;
                    if (r_tx_ready && bus.tx_valid) begin
                        r_tx_ready <= 1'b0;
                        r_tx_shift <= bus.tx_data;
                        r_txd      <= 1'b0;
                        r_tx_cnt   <= '0;
                        r_tx_state <= ST_START;
                    end else begin
                        r_tx_ready <= 1'b1;
                    end
                end
                ST_START: begin
                    if (r_tx_cnt == CNT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[DATA_W-1:1]};
                        r_tx_state <= ST_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (r_tx_cnt == CNT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_txd      <= 1'b1;
                            r_tx_state <= ST_STOP;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_txd      <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[DATA_W-1:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (r_tx_cnt == CNT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_ready <= 1'b1;
                        r_tx_state <= ST_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                default: r_tx_state <= ST_IDLE;
            endcase
        end
    end

    // Stop-bit verdicts; r_rx_brk blocks repeats while waiting out a low line
    assign w_rx_done = (r_rx_state == ST_STOP) && !r_rx_brk && (r_rx_cnt == CNT_LAST) &&  r_rxd_sync;
    assign w_rx_ferr = (r_rx_state == ST_STOP) && !r_rx_brk && (r_rx_cnt == CNT_LAST) && !r_rxd_sync;

    // Receiver: 2-flop synchronizer, then mid-bit sampling FSM
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_brk   <= 1'b0;
        end else begin
            r_rxd_meta <= bus.uart_rxd;
            r_rxd_sync <= r_rxd_meta;
            case (r_rx_state)
                ST_IDLE: begin
                    r_rx_brk <= 1'b0;
                    if (!r_rxd_sync) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rxd_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (r_rx_cnt == CNT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rxd_sync, r_rx_shift[DATA_W-1:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= ST_STOP;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (r_rx_brk) begin
                        if (r_rxd_sync) begin
                            r_rx_brk   <= 1'b0;
                            r_rx_state <= ST_IDLE;
                        end
                    end else if (r_rx_cnt == CNT_LAST) begin
                        r_rx_cnt <= '0;
                        if (r_rxd_sync) begin
                            r_rx_state <= ST_IDLE;
                        end else begin
                            r_rx_brk <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                default: r_rx_state <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    logic w_fifo_ready;

    yarvi_uart_fifo u_fifo (
        .i_clk     (clock),
        .i_rst_n   (reset_n),
        .i_valid   (w_rx_done),
        .i_data    (r_rx_shift),
        .o_ready_c (w_fifo_ready),
        .o_valid   (bus.rx_valid),
        .o_data    (bus.rx_data),
        .i_ready   (bus.rx_ready)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= w_rx_done && !w_fifo_ready;
            r_frame_err <= w_rx_ferr;
        end
    end
`else
    logic              r_hold_valid;
    logic [DATA_W-1:0] r_hold_data;

    assign bus.rx_valid = r_hold_valid;
    assign bus.rx_data  = r_hold_data;

    // Single holding register; a same-cycle pop frees it for the new byte
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= w_rx_ferr;
            r_overrun   <= w_rx_done && r_hold_valid && !bus.rx_ready;
            if (w_rx_done && (!r_hold_valid || bus.rx_ready)) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= r_rx_shift;
            end else if (r_hold_valid && bus.rx_ready) begin
                r_hold_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: doc/yarvi_uart.md
YARVI_UART -- requirements
Module: yarvi_uart

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, the clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, the serial bit rate.
REQ-003 SHALL derive DIV = CLK_HZ/BAUD, integer truncated, 434 at defaults; DIV SHALL be at least 4.
REQ-004 clock  in  1  sole clock; all logic on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 tx_valid  in  1  byte from SoC is valid.
REQ-007 tx_ready  out  1  transmitter can accept a byte.
REQ-008 tx_data  in  8  byte to transmit.
REQ-009 rx_valid  out  1  received byte is available.
REQ-010 rx_ready  in  1  SoC consumes the received byte.
REQ-011 rx_data  out  8  received byte.
REQ-012 uart_txd  out  1  serial line out, 8N1, idle high.
REQ-013 uart_rxd  in  1  serial line in, asynchronous.
REQ-014 rx_overrun  out  1  one-cycle pulse when a completed byte is dropped.
REQ-015 rx_frame_err  out  1  one-cycle pulse when a stop bit is sampled low.

Function
REQ-016 TX SHALL use FSM IDLE->START->DATA->STOP->IDLE; tx_ready SHALL be 1 only in IDLE.
REQ-017 A transfer SHALL occur on tx_valid&tx_ready; tx_data SHALL be latched in that cycle.
REQ-018 Frame timing from the cycle after acceptance: uart_txd=0 for DIV cycles, then data bits LSB first for DIV cycles each, then 1 for DIV cycles.
REQ-019 tx_ready SHALL reassert exactly 10*DIV cycles after acceptance; back-to-back frames SHALL have no idle gap.
REQ-020 uart_rxd SHALL pass a 2-flop synchronizer before any use.
REQ-021 RX SHALL use FSM IDLE->START->DATA->STOP->IDLE; IDLE leaves on synchronized low.
REQ-022 START SHALL resample after DIV/2 cycles; if high, it SHALL return to IDLE with no output (glitch reject).
REQ-023 DATA SHALL sample 8 bits at DIV-cycle intervals at bit centre, LSB first.
REQ-024 STOP SHALL sample at bit centre; a high stop bit delivers the byte, a low one discards it and pulses rx_frame_err.
REQ-025 After a low stop bit, RX SHALL wait in STOP until the line is high before entering IDLE.
REQ-026 rx_valid/rx_data SHALL hold stable until rx_valid&rx_ready.
REQ-027 If storage is full when a byte completes, the new byte SHALL be dropped and rx_overrun pulsed.
REQ-028 If rx_ready pops in the same cycle a byte completes into full storage, the new byte SHALL be kept and no overrun raised.
REQ-029 TX and RX SHALL operate fully independently (full duplex).
REQ-030 Bit-timing counters SHALL be ceil(log2(DIV)) bits wide and SHALL reload on reaching DIV-1, never wrapping past it.

Reset
REQ-031 While reset_n=0 at a clock edge: both FSMs to IDLE; uart_txd=1; tx_ready=0; rx_valid=0; rx_overrun=0; rx_frame_err=0; storage emptied.
REQ-032 tx_ready SHALL be 1 in the first cycle after reset_n rises.
REQ-033 Reset mid-frame SHALL abandon the frame; uart_txd=1 from the next cycle and the partial RX byte is never delivered.

Configuration
REQ-034 Macro UART_RX_FIFO_EN defined: RX storage SHALL be a 4-entry FIFO; order SHALL be preserved; overrun only when 4 bytes are held.
REQ-035 Macro UART_RX_FIFO_EN undefined: RX storage SHALL be a single holding register; overrun when 1 byte is held.

Structure
REQ-036 Package yarvi_uart_pkg SHALL hold the TX/RX state enum typedef, the FIFO depth constant (4) and the frame-bit-count constant (10).
REQ-037 The RX FIFO SHALL be sub-module yarvi_uart_fifo (8-bit, depth 4, valid/ready on both sides), instantiated only under UART_RX_FIFO_EN.

Verification (CLK_HZ=400, BAUD=100, DIV=4)
REQ-038 Send tx_data=0xA5 -> uart_txd reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_ready returns 40 cycles after acceptance.
REQ-039 Loop uart_txd to uart_rxd, send 0x3C with rx_ready=1 -> rx_valid with rx_data=0x3C, no error pulses.
REQ-040 Drive a 1-cycle low glitch on uart_rxd -> no rx_valid, no rx_frame_err; RX back in IDLE.
REQ-041 Send a frame for 0x55 with stop bit 0 -> rx_frame_err pulses once; no rx_valid.
REQ-042 Hold rx_ready=0 and send 0x01,0x02 (no FIFO) or 0x01..0x05 (FIFO) -> last byte dropped with one rx_overrun pulse; then draining yields 0x01 (or 0x01..0x04) in order.
REQ-043 Assert reset_n=0 during TX bit 3 -> uart_txd=1 next cycle; tx_ready=1 the cycle after reset_n rises.
